// File: rtl/fmul_pkg.sv
// Shared constants and types for the binary32 mantissa-multiply stage.
package fmul_pkg;

    localparam int unsigned EXP_BIAS = 127;
    localparam int unsigned MANT_W   = 24;
    localparam int unsigned PROD_W   = 48;
    localparam int unsigned EXP_W    = 9;
    localparam int unsigned CNT_W    = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_e;

    // One unpacked binary32 operand.
    typedef struct packed {
        logic              sign;
        logic [7:0]        exp;
        logic [MANT_W-1:0] mant;
        logic              is_zero;
    } fp_unpacked_t;

endpackage

// File: rtl/fmul_unpack.sv
// fmul_unpack: combinational binary32 unpacker.
//   x   : binary32 operand
//   op  : sign, biased exponent, 24-bit significand with hidden bit, +-0 flag
module fmul_unpack
    import fmul_pkg::*;
(
    input  logic [31:0]  x,
    output fp_unpacked_t op
);

    // Hidden bit is set for every non-zero exponent (subnormals get 0).
    always_comb begin
        op.sign    = x[31];
        op.exp     = x[30:23];
        op.mant    = {(x[30:23] != 8'd0), x[22:0]};
        op.is_zero = (x[30:0] == 31'd0);
    end

endmodule

// File: rtl/fmul_mant.sv
// fmul_mant: iterative 24-step shift-add significand multiplier.
//   clk, rst              : clock, synchronous active-high reset
//   in_valid / in_ready   : operand handshake (A, B binary32)
//   out_valid / out_ready : result handshake (sign, reg_c, expc2)
//   sign  : A[31] ^ B[31]
//   reg_c : exact 48-bit product of the 24-bit significands
//   expc2 : eA + eB - 127, modulo 512 (bit 8 flags out of range)
// Optional feature: FMUL_ZERO_BYPASS_EN sends +-0 operands straight to DONE.
module fmul_mant
    import fmul_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       A,
    input  logic [31:0]       B,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              sign,
    output logic [PROD_W-1:0] reg_c,
    output logic [EXP_W-1:0]  expc2
);

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(MANT_W - 1);

    fp_unpacked_t op_a;
    fp_unpacked_t op_b;

    fmul_unpack u_unpack_a (.x(A), .op(op_a));
    fmul_unpack u_unpack_b (.x(B), .op(op_b));

    state_e             state_q,     state_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic [MANT_W-1:0]  ma_q,        ma_d;
    logic [MANT_W-1:0]  hi_q,        hi_d;
    logic [MANT_W-1:0]  lo_q,        lo_d;
    logic               sign_q,      sign_d;
    logic [EXP_W-1:0]   expc2_q,     expc2_d;
    logic               in_ready_q,  in_ready_d;
    logic               out_valid_q, out_valid_d;

    logic [MANT_W:0]    step_sum;
    logic [EXP_W-1:0]   exp_sum;
    logic               accept;

    // {carry, hi} after the conditional add of the multiplicand.
    always_comb begin
        step_sum = {1'b0, hi_q};
        if (lo_q[0]) begin
            step_sum = {1'b0, hi_q} + {1'b0, ma_q};
        end
    end

    // Biased exponent sum, wrapping modulo 2^EXP_W.
    always_comb begin
        exp_sum = EXP_W'({1'b0, op_a.exp}) + EXP_W'({1'b0, op_b.exp})
                - EXP_W'(EXP_BIAS);
    end

    assign accept = in_valid & in_ready_q;

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ma_d        = ma_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        sign_d      = sign_q;
        expc2_d     = expc2_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    ma_d       = op_a.mant;
                    hi_d       = '0;
                    lo_d       = op_b.mant;
                    cnt_d      = '0;
                    sign_d     = op_a.sign ^ op_b.sign;
                    expc2_d    = exp_sum;
                    in_ready_d = 1'b0;
                    state_d    = MUL;
`ifdef FMUL_ZERO_BYPASS_EN
                    if (op_a.is_zero || op_b.is_zero) begin
                        lo_d        = '0;
                        expc2_d     = '0;
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end
`endif
                end
            end
            MUL: begin
                // Shift {carry, hi, lo} right by one; carry leaves as zero.
                hi_d = step_sum[MANT_W:1];
                lo_d = {step_sum[0], lo_q[MANT_W-1:1]};
                if (cnt_q == LAST_STEP) begin
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ma_q        <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            sign_q      <= 1'b0;
            expc2_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ma_q        <= ma_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            sign_q      <= sign_d;
            expc2_q     <= expc2_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sign      = sign_q;
    assign reg_c     = {hi_q, lo_q};
    assign expc2     = expc2_q;

endmodule

// File: tb/tb_fmul_mant.sv
// Randomized self-checking bench for fmul_mant against an arithmetic model.
module tb_fmul_mant;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic        out_valid;
    logic        out_ready;
    logic        sign;
    logic [47:0] reg_c;
    logic [8:0]  expc2;

    int n_checks;
    int n_errors;
    bit bypass;

    fmul_mant dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sign      (sign),
        .reg_c     (reg_c),
        .expc2     (expc2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain arithmetic on the binary32 fields.
    function automatic bit is_zero_op(input logic [31:0] x);
        return (x & 32'h7fff_ffff) == 32'd0;
    endfunction

    function automatic longint unsigned ref_mant(input logic [31:0] x);
        longint unsigned e;
        e = longint'((x >> 23) & 32'hff);
        return (e != 0 ? 64'h80_0000 : 64'h0) + longint'(x & 32'h7f_ffff);
    endfunction

    task automatic ref_model(input logic [31:0] a, input logic [31:0] b,
                             output logic s, output logic [47:0] p,
                             output logic [8:0] e, output int lat);
        int ea, eb, es;
        longint unsigned prod;
        ea   = int'((a >> 23) & 32'hff);
        eb   = int'((b >> 23) & 32'hff);
        es   = ea + eb - 127;
        if (es < 0) es += 512;
        prod = ref_mant(a) * ref_mant(b);
        s    = a[31] ^ b[31];
        p    = prod[47:0];
        e    = 9'(es % 512);
        lat  = 24;
        if (bypass && (is_zero_op(a) || is_zero_op(b))) begin
            p   = '0;
            e   = '0;
            lat = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction: accept, wait, optional stall, handshake.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input int stall, input string tag);
        logic        es;
        logic [47:0] ep;
        logic [8:0]  ee;
        int          elat;
        int          lat;
        ref_model(a, b, es, ep, ee, elat);
        check({tag, ".in_ready_idle"}, 64'(in_ready), 64'd1);
        A         = a;
        B         = b;
        in_valid  = 1'b1;
        out_ready = (stall == 0) ? 1'b1 : 1'b0;
        tick();
        in_valid = 1'b0;
        A        = $urandom;
        B        = $urandom;
        check({tag, ".in_ready_busy"}, 64'(in_ready), 64'd0);
        lat = 0;
        while (!out_valid && lat < 200) begin
            tick();
            lat++;
        end
        check({tag, ".latency"}, 64'(lat), 64'(elat));
        check({tag, ".sign"}, 64'(sign), 64'(es));
        check({tag, ".reg_c"}, 64'(reg_c), 64'(ep));
        check({tag, ".expc2"}, 64'(expc2), 64'(ee));
        for (int i = 0; i < stall; i++) begin
            tick();
            check({tag, ".stall_valid"}, 64'(out_valid), 64'd1);
            check({tag, ".stall_in_ready"}, 64'(in_ready), 64'd0);
            check({tag, ".stall_data"}, {15'd0, sign, reg_c}, {15'd0, es, ep});
            check({tag, ".stall_exp"}, 64'(expc2), 64'(ee));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, ".post_valid"}, 64'(out_valid), 64'd0);
        check({tag, ".post_in_ready"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        n_checks  = 0;
        n_errors  = 0;
`ifdef FMUL_ZERO_BYPASS_EN
        bypass = 1'b1;
`else
        bypass = 1'b0;
`endif
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        A         = '0;
        B         = '0;
        repeat (3) tick();
        check("rst.in_ready", 64'(in_ready), 64'd1);
        check("rst.out_valid", 64'(out_valid), 64'd0);
        check("rst.data", {15'd0, sign, reg_c}, 64'd0);
        check("rst.expc2", 64'(expc2), 64'd0);
        rst = 1'b0;
        tick();

        // Directed cases; expectations stated as literal constants too.
        run_op(32'h3F80_0000, 32'h3F80_0000, 0, "one_x_one");
        check("one_x_one.const", 64'(reg_c), 64'h4000_0000_0000);
        run_op(32'h3FC0_0000, 32'h3FC0_0000, 2, "onehalf_sq");
        check("onehalf_sq.const", 64'(reg_c), 64'h9000_0000_0000);
        run_op(32'hC000_0000, 32'h4040_0000, 0, "neg2_x_3");
        check("neg2_x_3.exp_const", 64'(expc2), 64'd129);
        run_op(32'h0080_0000, 32'h0080_0000, 1, "exp_wrap");
        check("exp_wrap.const", 64'(expc2), 64'h183);
        run_op(32'h3F80_0000, 32'h4040_0000, 5, "backpressure");
        run_op(32'h0000_0000, 32'h4040_0000, 0, "zero_a");
        check("zero_a.exp_const", 64'(expc2), bypass ? 64'd0 : 64'd1);
        run_op(32'hC040_0000, 32'h8000_0000, 3, "zero_b_neg");
        run_op(32'h7FFF_FFFF, 32'h7FFF_FFFF, 0, "max_mant");

        // Reset in the middle of a multiply.
        A        = 32'h3FC0_0000;
        B        = 32'h4040_0000;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst.out_valid", 64'(out_valid), 64'd0);
        check("midrst.in_ready", 64'(in_ready), 64'd1);
        check("midrst.data", {15'd0, sign, reg_c}, 64'd0);
        check("midrst.expc2", 64'(expc2), 64'd0);
        run_op(32'h4000_0000, 32'h4000_0000, 0, "after_rst");

        // Random operands, some forced to +-0, random stalls.
        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 7) == 0) ra = {ra[31], 31'd0};
            if ($urandom_range(0, 7) == 0) rb = {rb[31], 31'd0};
            if ($urandom_range(0, 5) == 0) ra[30:23] = 8'd0;
            run_op(ra, rb, int'($urandom_range(0, 3)), $sformatf("rnd%0d", i));
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
